// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios II PIO blocks: register map, edge
// encodings, the Avalon command payload and a constant clog2 helper.
package nios_pio_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  // Word addresses of the PIO register map
  localparam logic [ADDR_W-1:0] ADDR_DATA     = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD     = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 2'd3;

  // Edge qualification encodings for EDGE_TYPE
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Decoded Avalon-MM slave command for one clock
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              wr_en;
    logic [DATA_W-1:0] writedata;
  } avs_cmd_t;

  // Ceiling log2; clog2(0) = clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_pio_debounce_bit.sv
// One input pin: 2-flop synchronizer followed by an optional debounce
// filter that only accepts a new level after it has been held for
// DEBOUNCE_CYCLES consecutive clocks.
//   clk, reset : system clock, synchronous active-high reset
//   pin        : asynchronous external pin
//   stable     : filtered, synchronous pin level
module nios_pio_debounce_bit
  import nios_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable
);

  logic sync1;
  logic sync2;

  // Metastability synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: a single register stage after the synchronizer
      always_ff @(posedge clk) begin
        if (reset) stable <= RESET_VALUE;
        else       stable <= sync2;
      end
    end else begin : g_filter
      localparam int unsigned CNT_W =
        (clog2(DEBOUNCE_CYCLES) > 0) ? clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] count;

      // Count while the synchronized level disagrees; any return to the
      // accepted level restarts the count, so short glitches are dropped.
      always_ff @(posedge clk) begin
        if (reset) begin
          count  <= '0;
          stable <= RESET_VALUE;
        end else if (sync2 == stable) begin
          count  <= '0;
        end else if (count == CNT_LAST) begin
          stable <= sync2;
          count  <= '0;
        end else begin
          count  <= count + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/nios_pio_in.sv
// Avalon-MM input PIO: synchronized/debounced pins, edge capture with
// write-1-to-clear, interrupt mask and a maskable level interrupt.
//   clk, reset  : system clock, synchronous active-high reset
//   address     : word address (0 data, 1 reserved, 2 irq_mask, 3 edge_capture)
//   chipselect  : slave select
//   write_n     : active-low write strobe
//   writedata   : write data, only [WIDTH-1:0] used
//   in_port     : asynchronous external pins
//   readdata    : registered read data, latency 1, upper bits zero
//   irq         : level interrupt, |(edge_capture & irq_mask)
module nios_pio_in
  import nios_pio_pkg::*;
#(
  parameter int unsigned     WIDTH           = 5,
  parameter int unsigned     DEBOUNCE_CYCLES = 0,
  parameter int unsigned     EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  avs_cmd_t         cmd;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic             mask_we;
  logic [31:0]      rd_next;

  // Bus command decode
  always_comb begin
    cmd.address   = address;
    cmd.wr_en     = chipselect & ~write_n;
    cmd.writedata = writedata;
  end

  generate
    if (WIDTH < DATA_W) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^cmd.writedata[DATA_W-1:WIDTH];
    end
  endgenerate

  // Per-pin synchronizer and debounce
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      nios_pio_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (IN_RESET_VALUE[i])
      ) u_bit (
        .clk    (clk),
        .reset  (reset),
        .pin    (in_port[i]),
        .stable (stable[i])
      );
    end
  endgenerate

  // Edge qualification
  always_comb begin
    edge_hit = stable & ~stable_d;
    if (EDGE_TYPE == EDGE_FALLING)  edge_hit = ~stable & stable_d;
    else if (EDGE_TYPE == EDGE_ANY) edge_hit = stable ^ stable_d;
  end

  // Register write decode
  always_comb begin
    mask_we = cmd.wr_en && (cmd.address == ADDR_IRQ_MASK);
    cap_clr = '0;
    if (cmd.wr_en && (cmd.address == ADDR_EDGE_CAP)) cap_clr = cmd.writedata[WIDTH-1:0];
  end

  // Read mux, zero-extended
  always_comb begin
    rd_next = '0;
    case (cmd.address)
      ADDR_DATA:     rd_next = DATA_W'(stable);
      ADDR_IRQ_MASK: rd_next = DATA_W'(irq_mask);
      ADDR_EDGE_CAP: rd_next = DATA_W'(edge_capture);
      default:       rd_next = '0;
    endcase
  end

  // Register state; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d     <= IN_RESET_VALUE;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      stable_d     <= stable;
      if (mask_we) irq_mask <= cmd.writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~cap_clr) | edge_hit;
      readdata     <= rd_next;
    end
  end

  // Level interrupt straight from registers so unmasking takes effect at once
  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_pio_in.sv
// Directed bench for nios_pio_in. Two instances share the bus:
// dut_a debounces (4 cycles, rising edges), dut_b bypasses the filter
// and captures any edge. Read results go through an expectation queue.
module tb_nios_pio_in;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        cs_a;
  logic        cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [4:0]  in_a;
  logic [4:0]  in_b;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        irq_a;
  logic        irq_b;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          sel_b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  nios_pio_in #(
    .WIDTH(5), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IN_RESET_VALUE(5'h00)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  nios_pio_in #(
    .WIDTH(5), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IN_RESET_VALUE(5'h00)
  ) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL sb_empty: observed empty queue expected entry");
    end else begin
      e = sb.pop_front();
      check(e.tag, e.sel_b ? rd_b : rd_a, e.exp);
    end
  endtask

  task automatic rd(input bit sel_b, input logic [1:0] addr, input logic [31:0] exp,
                    input string tag);
    address = addr;
    sb.push_back('{tag, exp, sel_b});
    tick();
    pop_check();
  endtask

  task automatic wr(input bit sel_b, input logic [1:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    write_n   = 1'b0;
    cs_a      = ~sel_b;
    cs_b      = sel_b;
    tick();
    write_n   = 1'b1;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; cs_a = 1'b0; cs_b = 1'b0;
    write_n = 1'b1; writedata = '0; in_a = '0; in_b = '0;
    ticks(2);
    reset = 1'b0;

    // 1. reset state on every address
    for (int a = 0; a < 4; a++) rd(1'b0, 2'(a), 32'h0, $sformatf("a_rst_addr%0d", a));
    for (int a = 0; a < 4; a++) rd(1'b1, 2'(a), 32'h0, $sformatf("b_rst_addr%0d", a));
    check("a_rst_irq", 32'(irq_a), 32'h0);
    check("b_rst_irq", 32'(irq_b), 32'h0);

    // 2. debounced rising edge: stable at edge 6, capture/irq at edge 7
    wr(1'b0, 2'd2, 32'h1);
    in_a    = 5'h01;
    address = 2'd0;
    for (int e = 1; e <= 7; e++) begin
      sb.push_back('{$sformatf("a_data_e%0d", e), (e >= 7) ? 32'h1 : 32'h0, 1'b0});
      tick();
      pop_check();
      check($sformatf("a_irq_e%0d", e), 32'(irq_a), (e >= 7) ? 32'h1 : 32'h0);
    end
    rd(1'b0, 2'd3, 32'h1, "a_cap_rise");
    rd(1'b0, 2'd0, 32'h1, "a_data_rise");

    // 3. 3-cycle glitch on bit 2 is filtered out
    wr(1'b0, 2'd3, 32'h1);
    rd(1'b0, 2'd3, 32'h0, "a_cap_cleared");
    check("a_irq_cleared", 32'(irq_a), 32'h0);
    in_a = 5'h05;
    ticks(3);
    in_a = 5'h01;
    ticks(8);
    rd(1'b0, 2'd0, 32'h1, "a_data_glitch");
    rd(1'b0, 2'd3, 32'h0, "a_cap_glitch");
    check("a_irq_glitch", 32'(irq_a), 32'h0);

    // 4. falling edge ignored, then two rising edges; mask and W1C
    in_a = 5'h00;
    ticks(10);
    rd(1'b0, 2'd3, 32'h0, "a_cap_fall_ignored");
    in_a = 5'h03;
    ticks(10);
    wr(1'b0, 2'd2, 32'h0);
    check("a_irq_masked", 32'(irq_a), 32'h0);
    rd(1'b0, 2'd3, 32'h3, "a_cap_masked_kept");
    wr(1'b0, 2'd2, 32'h3);
    check("a_irq_unmasked", 32'(irq_a), 32'h1);
    wr(1'b0, 2'd3, 32'h1);
    rd(1'b0, 2'd3, 32'h2, "a_cap_clr_bit0");
    check("a_irq_bit1_pending", 32'(irq_a), 32'h1);
    wr(1'b0, 2'd3, 32'h2);
    rd(1'b0, 2'd3, 32'h0, "a_cap_clr_bit1");
    check("a_irq_all_clear", 32'(irq_a), 32'h0);
    rd(1'b0, 2'd1, 32'h0, "a_rsvd");

    // 5a. clear and new edge on the same clock: set wins
    wr(1'b1, 2'd2, 32'h3);
    in_b = 5'h01;
    ticks(3);
    wr(1'b1, 2'd3, 32'h1);
    rd(1'b1, 2'd3, 32'h1, "b_set_wins");
    wr(1'b1, 2'd3, 32'h1);
    rd(1'b1, 2'd3, 32'h0, "b_plain_clear");

    // 5b. any-edge capture on bit 1: rise then fall
    in_b = 5'h03;
    ticks(4);
    rd(1'b1, 2'd3, 32'h2, "b_cap_rise");
    check("b_irq_rise", 32'(irq_b), 32'h1);
    wr(1'b1, 2'd3, 32'h2);
    rd(1'b1, 2'd3, 32'h0, "b_cap_clr1");
    check("b_irq_clr1", 32'(irq_b), 32'h0);
    in_b = 5'h01;
    ticks(4);
    rd(1'b1, 2'd3, 32'h2, "b_cap_fall");
    wr(1'b1, 2'd3, 32'h2);
    rd(1'b1, 2'd3, 32'h0, "b_cap_clr2");

    // 6. mask width, then reset mid-debounce with a pending capture on b
    wr(1'b0, 2'd2, 32'hFFFF_FFFF);
    rd(1'b0, 2'd2, 32'h1F, "a_mask_width");
    in_b = 5'h03;
    in_a = 5'h07;
    ticks(4);
    check("b_irq_before_reset", 32'(irq_b), 32'h1);
    reset = 1'b1;
    in_a  = 5'h00;
    in_b  = 5'h00;
    tick();
    reset = 1'b0;
    check("a_rd_after_reset", rd_a, 32'h0);
    check("a_irq_after_reset", 32'(irq_a), 32'h0);
    check("b_irq_after_reset", 32'(irq_b), 32'h0);
    ticks(8);
    rd(1'b0, 2'd0, 32'h0, "a_data_post_reset");
    rd(1'b0, 2'd2, 32'h0, "a_mask_post_reset");
    rd(1'b0, 2'd3, 32'h0, "a_cap_post_reset");
    rd(1'b1, 2'd2, 32'h0, "b_mask_post_reset");
    rd(1'b1, 2'd3, 32'h0, "b_cap_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
